// File: rtl/fxp_i2s_tx.sv
// Mono I2S transmitter: buffers fixed-point samples in a small FIFO and sends each one to both
// slots. Build option I2S_TX_HOLD_ON_UNDERRUN_EN repeats the last word on underrun (else silence).
module fxp_i2s_tx #(
   parameter int unsigned fxp_size   = 16,
   parameter int unsigned dac_bits   = 24,
   parameter int unsigned sclk_div   = 4,
   parameter int unsigned fifo_depth = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [fxp_size-1:0] i_sample,
   output logic                o_ready,
   output logic                o_sclk,
   output logic                o_lrclk,
   output logic                o_sdata,
   output logic                o_underrun,
   output logic                o_overflow
);

   localparam int unsigned AddrW = $clog2(fifo_depth);
   localparam int unsigned CntW  = AddrW + 1;
   localparam int unsigned DivW  = $clog2(sclk_div);
   localparam int unsigned BitW  = $clog2(2 * dac_bits);
   localparam int unsigned SelW  = $clog2(dac_bits);

   logic [fxp_size-1:0] mem_q [fifo_depth];
   logic [AddrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     count_q, count_d;
   logic                ready_q, ready_d;
   logic [DivW-1:0]     div_q, div_d;
   logic                sclk_q, sclk_d;
   logic [BitW-1:0]     bit_q, bit_d;
   logic                lrclk_q, lrclk_d;
   logic                sdata_q, sdata_d;
   logic [dac_bits-1:0] word_q, word_d;
   logic                underrun_q, underrun_d;
   logic                overflow_q, overflow_d;

   logic                push, pop, div_wrap, fall, frame_end;
   logic [BitW-1:0]     sel;
   logic [dac_bits-1:0] head_word;

   always_comb begin
      push      = valid && ready_q;
      div_wrap  = (div_q == DivW'(sclk_div - 1));
      fall      = div_wrap && sclk_q;
      frame_end = fall && (bit_q == BitW'(2 * dac_bits - 1));
      pop       = frame_end && (count_q != '0);

      head_word = '0;
      head_word[dac_bits-1 -: fxp_size] = mem_q[rd_ptr_q];

      // Both slots walk the same word MSB first; bit_q is the pre-advance count.
      if (bit_q < BitW'(dac_bits)) begin
         sel = BitW'(dac_bits - 1) - bit_q;
      end else begin
         sel = BitW'(2 * dac_bits - 1) - bit_q;
      end

      div_d      = div_wrap ? '0 : div_q + DivW'(1);
      sclk_d     = div_wrap ? ~sclk_q : sclk_q;
      bit_d      = bit_q;
      lrclk_d    = lrclk_q;
      sdata_d    = sdata_q;
      word_d     = word_q;
      underrun_d = frame_end && (count_q == '0);
      overflow_d = valid && !ready_q;

      if (fall) begin
         bit_d   = frame_end ? '0 : bit_q + BitW'(1);
         lrclk_d = (bit_q >= BitW'(dac_bits - 1)) && (bit_q <= BitW'(2 * dac_bits - 2));
         sdata_d = word_q[SelW'(sel)];
      end

      if (frame_end) begin
         if (pop) begin
            word_d = head_word;
         end else begin
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
            word_d = word_q;
`else
            word_d = '0;
`endif
         end
      end

      wr_ptr_d = push ? wr_ptr_q + AddrW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AddrW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      ready_d = (count_d != CntW'(fifo_depth));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ready_q    <= 1'b1;
         div_q      <= '0;
         sclk_q     <= 1'b0;
         bit_q      <= '0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         word_q     <= '0;
         underrun_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         bit_q      <= bit_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         word_q     <= word_d;
         underrun_q <= underrun_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_sample;
      end
   end

   assign o_ready    = ready_q;
   assign o_sclk     = sclk_q;
   assign o_lrclk    = lrclk_q;
   assign o_sdata    = sdata_q;
   assign o_underrun = underrun_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_fxp_i2s_tx.sv
// Directed bench for fxp_i2s_tx: decodes I2S frames and checks them against hand-computed words.
// Two instances: default parameters and sclk_div=2.
module tb_fxp_i2s_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        valid1 = 1'b0, valid2 = 1'b0;
   logic [15:0] sample1 = '0, sample2 = '0;
   logic        ready1, sclk1, lrclk1, sdata1, underrun1, overflow1;
   logic        ready2, sclk2, lrclk2, sdata2, underrun2, overflow2;

   int checks = 0;
   int failures = 0;
   int und1 = 0, ovf1 = 0, und2 = 0, ovf2 = 0;

   fxp_i2s_tx #(.fxp_size(16), .dac_bits(24), .sclk_div(4), .fifo_depth(4)) u_dut1 (
      .clk(clk), .rst(rst), .valid(valid1), .i_sample(sample1), .o_ready(ready1),
      .o_sclk(sclk1), .o_lrclk(lrclk1), .o_sdata(sdata1), .o_underrun(underrun1),
      .o_overflow(overflow1)
   );

   fxp_i2s_tx #(.fxp_size(16), .dac_bits(24), .sclk_div(2), .fifo_depth(4)) u_dut2 (
      .clk(clk), .rst(rst), .valid(valid2), .i_sample(sample2), .o_ready(ready2),
      .o_sclk(sclk2), .o_lrclk(lrclk2), .o_sdata(sdata2), .o_underrun(underrun2),
      .o_overflow(overflow2)
   );

   // Pulse counters; a pulse registered at edge N is counted at edge N+1.
   always @(posedge clk) begin
      if (underrun1 === 1'b1) und1++;
      if (overflow1 === 1'b1) ovf1++;
      if (underrun2 === 1'b1) und2++;
      if (overflow2 === 1'b1) ovf2++;
   end

   function automatic logic sclk_of(input int w);
      return (w == 2) ? sclk2 : sclk1;
   endfunction
   function automatic logic lr_of(input int w);
      return (w == 2) ? lrclk2 : lrclk1;
   endfunction
   function automatic logic sd_of(input int w);
      return (w == 2) ? sdata2 : sdata1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_wrap(input int w, input string tag);
      logic prev;
      bit   found;
      int   cyc;
      prev  = lr_of(w);
      found = 1'b0;
      cyc   = 0;
      while (!found && cyc < 600) begin
         @(negedge clk);
         cyc++;
         if (prev && !lr_of(w)) found = 1'b1;
         prev = lr_of(w);
      end
      chk({tag, "_wrap_seen"}, 32'(found), 32'd1);
   endtask

   // Called right after a frame-start fall; collects the next 48 falls.
   task automatic frame(input int w, input string tag, input logic [23:0] exp);
      logic [23:0] l, r;
      logic        prev, cur;
      int          falls, cyc, lr_err;
      l = '0; r = '0; falls = 0; cyc = 0; lr_err = 0;
      prev = sclk_of(w);
      while (falls < 48 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         cur = sclk_of(w);
         if (prev && !cur) begin
            falls++;
            if (falls <= 24) l = {l[22:0], sd_of(w)};
            else r = {r[22:0], sd_of(w)};
            if (lr_of(w) !== ((falls >= 24 && falls <= 47) ? 1'b1 : 1'b0)) lr_err++;
         end
         prev = cur;
      end
      chk({tag, "_falls"}, 32'(falls), 32'd48);
      chk({tag, "_left"}, {8'h0, l}, {8'h0, exp});
      chk({tag, "_right"}, {8'h0, r}, {8'h0, exp});
      chk({tag, "_lrclk_errs"}, 32'(lr_err), 32'd0);
   endtask

   logic [15:0] s [101];
   int          base_und, base_ovf;
   logic [23:0] under_word;

   initial begin
      // Power-on reset, 3 clk.
      repeat (3) @(negedge clk);
      chk("rst_sclk", 32'(sclk1), 32'd0);
      chk("rst_lrclk", 32'(lrclk1), 32'd0);
      chk("rst_sdata", 32'(sdata1), 32'd0);
      chk("rst_ready", 32'(ready1), 32'd1);
      chk("rst_underrun", 32'(underrun1), 32'd0);
      chk("rst_overflow", 32'(overflow1), 32'd0);
      rst = 1'b0;

      // sclk_div=2 instance: fill, then full FIFO meets pop, then push+pop together.
      valid2 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         sample2 = 16'(i * 16'h1001);
         @(negedge clk);
      end
      valid2 = 1'b0;
      chk("d2_ready_full", 32'(ready2), 32'd0);
      wait_wrap(2, "d2_first");                 // pops 1001
      chk("d2_ready_after_pop", 32'(ready2), 32'd1);
      valid2 = 1'b1; sample2 = 16'h5005;
      @(negedge clk);
      valid2 = 1'b0;
      chk("d2_ready_refull", 32'(ready2), 32'd0);
      repeat (190) @(negedge clk);
      valid2 = 1'b1; sample2 = 16'h6006;        // lands on the pop edge while full: dropped
      @(negedge clk);
      valid2 = 1'b0;
      chk("d2_ovf_on_full_pop", 32'(overflow2), 32'd1);
      chk("d2_ready_after_pop2", 32'(ready2), 32'd1);
      repeat (191) @(negedge clk);
      valid2 = 1'b1; sample2 = 16'h7007;        // push and pop in the same clk, both taken
      @(negedge clk);
      valid2 = 1'b0;
      chk("d2_ovf_pushpop", 32'(overflow2), 32'd0);
      chk("d2_ready_pushpop", 32'(ready2), 32'd1);
      frame(2, "d2_f3003", 24'h300300);
      frame(2, "d2_f4004", 24'h400400);
      frame(2, "d2_f5005", 24'h500500);
      frame(2, "d2_f7007", 24'h700700);
      @(negedge clk);
      chk("d2_underrun_count", 32'(und2), 32'd1);
      chk("d2_overflow_count", 32'(ovf2), 32'd1);

      // Mid-frame reset held 3 clk.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("mrst_sclk", 32'(sclk1), 32'd0);
      chk("mrst_lrclk", 32'(lrclk1), 32'd0);
      chk("mrst_sdata", 32'(sdata1), 32'd0);
      chk("mrst_ready", 32'(ready1), 32'd1);
      chk("mrst_underrun", 32'(underrun1), 32'd0);
      chk("mrst_overflow", 32'(overflow1), 32'd0);
      rst = 1'b0;
      base_und = und1;

      wait_wrap(1, "first_frame");              // empty FIFO: underrun frame
      valid1 = 1'b1; sample1 = 16'h8001;
      @(negedge clk);
      sample1 = 16'h7FFF;
      @(negedge clk);
      valid1 = 1'b0;
      frame(1, "silence_after_rst", 24'h000000);
      chk("underrun_after_rst", 32'(und1 - base_und), 32'd1);
      frame(1, "f8001", 24'h800100);
      frame(1, "f7fff", 24'h7FFF00);
`ifdef I2S_TX_HOLD_ON_UNDERRUN_EN
      under_word = 24'h7FFF00;
`else
      under_word = 24'h000000;
`endif
      frame(1, "underrun_word", under_word);
      @(negedge clk);
      chk("underrun_count", 32'(und1 - base_und), 32'd3);

      // Five back-to-back pushes, no pop in between.
      base_ovf = ovf1;
      s[0] = 16'hA5A5; s[1] = 16'h0123; s[2] = 16'hFFFF; s[3] = 16'h8000; s[4] = 16'h4242;
      valid1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample1 = s[i];
         @(negedge clk);
         chk($sformatf("fill_ready%0d", i), 32'(ready1), (i < 3) ? 32'd1 : 32'd0);
         chk($sformatf("fill_ovf%0d", i), 32'(overflow1), (i == 4) ? 32'd1 : 32'd0);
      end
      valid1 = 1'b0;
      @(negedge clk);
      chk("ovf_one_cycle", 32'(overflow1), 32'd0);
      wait_wrap(1, "fill");
      frame(1, "fifo0", 24'hA5A500);
      frame(1, "fifo1", 24'h012300);
      frame(1, "fifo2", 24'hFFFF00);
      frame(1, "fifo3", 24'h800000);
      chk("ovf_count", 32'(ovf1 - base_ovf), 32'd1);
      @(negedge clk);

      // Stream of random samples, one pushed per frame.
      for (int i = 0; i < 101; i++) s[i] = 16'($urandom);
      base_und = und1;
      base_ovf = ovf1;
      valid1 = 1'b1; sample1 = s[0];
      @(negedge clk);
      valid1 = 1'b0;
      wait_wrap(1, "stream");
      for (int i = 0; i < 100; i++) begin
         valid1 = 1'b1; sample1 = s[i+1];
         @(negedge clk);
         valid1 = 1'b0;
         frame(1, $sformatf("stream%0d", i), {s[i], 8'h00});
      end
      @(negedge clk);
      chk("stream_underruns", 32'(und1 - base_und), 32'd0);
      chk("stream_overflows", 32'(ovf1 - base_ovf), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
